golden_nonce_fifo: RTL and testbench

- Downstream of the hashing/control stage in the hash_clk domain; consumes its golden-nonce strobe and 32-bit nonce.
- Applies pipeline-latency correction, suppresses back-to-back duplicates and buffers results in a small show-ahead FIFO.
- The communication block drains it with a valid/ack handshake, so nonces are not lost while the host is slow to poll.
- Reports overflow via a sticky flag and a saturating drop counter.

---
 rtl/miner_pkg.sv | 11 +
 rtl/sync_fifo_fwft.sv | 67 ++++++
 rtl/golden_nonce_fifo.sv | 91 +++++++++
 tb/tb_golden_nonce_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared miner types: nonce width and the drop-counter width used by the
// control, golden-nonce buffering and comm stages.
package miner_pkg;
  localparam int NONCE_W    = 32;
  localparam int DROP_CNT_W = 16;

  typedef logic [NONCE_W-1:0]    nonce_t;
  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  localparam drop_cnt_t DROP_CNT_MAX = '1;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic single-clock show-ahead FIFO: the head is visible on dout while
// valid=1; pop advances it. Flush empties the queue and beats push/pop.
module sync_fifo_fwft #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok, mem_we;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // A pop on a full queue frees the slot the push lands in.
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    mem_we   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      mem_we = push_ok;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= din;
  end

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/golden_nonce_fifo.sv
// Golden-nonce buffer: latency-corrects captured nonces, drops back-to-back
// duplicates, queues them for the comm block and accounts for overflow drops.
module golden_nonce_fifo
  import miner_pkg::*;
#(
  parameter int     DEPTH        = 8,
  parameter nonce_t NONCE_OFFSET = 32'd0,
  parameter bit     DEDUP        = 1'b1,
  localparam int    CW           = $clog2(DEPTH) + 1
) (
  input  logic                  hash_clk,
  input  logic                  rst_n,
  input  logic                  rx_new_nonce,
  input  logic [NONCE_W-1:0]    rx_golden_nonce,
  input  logic                  rx_flush,
  input  logic                  rx_ack,
  input  logic                  rx_clear_overflow,
  output logic [NONCE_W-1:0]    tx_nonce,
  output logic                  tx_valid,
  output logic [CW-1:0]         tx_count,
  output logic                  tx_overflow,
  output logic [DROP_CNT_W-1:0] tx_drop_count
);

  nonce_t    adj, last_nonce_q, last_nonce_d;
  logic      last_valid_q, last_valid_d;
  logic      overflow_q, overflow_d;
  drop_cnt_t drop_cnt_q, drop_cnt_d;
  logic      dup, push_req, pop, full, accept, drop;

  sync_fifo_fwft #(.DEPTH(DEPTH), .W(NONCE_W)) u_fifo (
    .clk   (hash_clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (adj),
    .pop   (rx_ack),
    .flush (rx_flush),
    .dout  (tx_nonce),
    .valid (tx_valid),
    .full  (full),
    .count (tx_count)
  );

  always_comb begin
    adj      = rx_golden_nonce - NONCE_OFFSET;
    dup      = DEDUP && last_valid_q && (adj == last_nonce_q);
    push_req = rx_new_nonce && !rx_flush && !dup;
    pop      = rx_ack && tx_valid;
    accept   = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    last_nonce_d = last_nonce_q;
    last_valid_d = last_valid_q;
    if (rx_flush) begin
      last_valid_d = 1'b0;
    end else if (accept) begin
      last_nonce_d = adj;
      last_valid_d = 1'b1;
    end

    // A drop in the same cycle as a clear restarts the count at one.
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (rx_clear_overflow)              drop_cnt_d = drop_cnt_t'(1);
      else if (drop_cnt_q != DROP_CNT_MAX) drop_cnt_d = drop_cnt_q + drop_cnt_t'(1);
    end else if (rx_clear_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_nonce_q <= '0;
      last_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      last_nonce_q <= last_nonce_d;
      last_valid_q <= last_valid_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign tx_overflow   = overflow_q;
  assign tx_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_golden_nonce_fifo.sv
// Bench for golden_nonce_fifo: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_golden_nonce_fifo;
  localparam int          DEPTH = 8;
  localparam logic [31:0] OFF   = 32'd2;
  localparam int          CW    = $clog2(DEPTH) + 1;

  logic          hash_clk = 1'b0;
  logic          rst_n;
  logic          rx_new_nonce, rx_flush, rx_ack, rx_clear_overflow;
  logic [31:0]   rx_golden_nonce;
  logic [31:0]   tx_nonce;
  logic          tx_valid, tx_overflow;
  logic [CW-1:0] tx_count;
  logic [15:0]   tx_drop_count;

  golden_nonce_fifo #(.DEPTH(DEPTH), .NONCE_OFFSET(OFF), .DEDUP(1'b1)) dut (
    .hash_clk          (hash_clk),
    .rst_n             (rst_n),
    .rx_new_nonce      (rx_new_nonce),
    .rx_golden_nonce   (rx_golden_nonce),
    .rx_flush          (rx_flush),
    .rx_ack            (rx_ack),
    .rx_clear_overflow (rx_clear_overflow),
    .tx_nonce          (tx_nonce),
    .tx_valid          (tx_valid),
    .tx_count          (tx_count),
    .tx_overflow       (tx_overflow),
    .tx_drop_count     (tx_drop_count)
  );

  always #5 hash_clk = ~hash_clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  logic        mlv, mov;
  logic [31:0] mln;
  logic [15:0] mdc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete(); mlv = 1'b0; mln = '0; mov = 1'b0; mdc = '0;
  endtask

  task automatic model_step();
    logic [31:0] adj;
    bit pop, drop, dup;
    adj  = rx_golden_nonce - OFF;
    pop  = rx_ack && (mq.size() > 0);
    drop = 1'b0;
    if (rx_flush) begin
      mq.delete();
      mlv = 1'b0;
    end else begin
      dup = mlv && (adj == mln);
      if (pop) void'(mq.pop_front());
      if (rx_new_nonce && !dup) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(adj); mln = adj; mlv = 1'b1;
        end else drop = 1'b1;
      end
    end
    if (drop) begin
      mov = 1'b1;
      if (rx_clear_overflow) mdc = 16'd1;
      else if (mdc != 16'hFFFF) mdc = mdc + 16'd1;
    end else if (rx_clear_overflow) begin
      mov = 1'b0; mdc = '0;
    end
  endtask

  task automatic compare_model();
    int n;
    n = mq.size();
    chk("m_valid", 32'(tx_valid), 32'(n > 0));
    chk("m_count", 32'(tx_count), 32'(n));
    chk("m_nonce", tx_nonce, (n > 0) ? mq[0] : 32'd0);
    chk("m_overflow", 32'(tx_overflow), 32'(mov));
    chk("m_dropcnt", 32'(tx_drop_count), 32'(mdc));
  endtask

  task automatic idle();
    rx_new_nonce = 0; rx_flush = 0; rx_ack = 0; rx_clear_overflow = 0;
    rx_golden_nonce = '0;
  endtask

  // Inputs are set by the caller at the falling edge and held across the rising edge.
  task automatic tick();
    @(posedge hash_clk);
    model_step();
    @(negedge hash_clk);
    compare_model();
  endtask

  task automatic push(input logic [31:0] raw);
    idle(); rx_new_nonce = 1; rx_golden_nonce = raw; tick();
  endtask

  logic [31:0] pool [4];

  initial begin
    pool = '{32'h0, 32'h1, 32'hDEADBEEF, 32'h7};
    idle();
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge hash_clk);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_count", 32'(tx_count), 32'd0);
    chk("rst_nonce", tx_nonce, 32'd0);
    chk("rst_ovf", 32'(tx_overflow), 32'd0);
    rst_n = 1'b1;

    // Offset correction wraps below zero.
    push(32'h1);
    chk("off_nonce", tx_nonce, 32'hFFFFFFFF);
    chk("off_valid", 32'(tx_valid), 32'd1);
    chk("off_count", 32'(tx_count), 32'd1);
    idle(); rx_flush = 1; tick();

    // Back-to-back duplicate suppressed.
    push(32'hA41F32E7 + OFF);
    push(32'hA41F32E7 + OFF);
    push(32'h12345678 + OFF);
    idle(); tick();
    chk("dup_count", 32'(tx_count), 32'd2);
    chk("dup_head0", tx_nonce, 32'hA41F32E7);
    idle(); rx_ack = 1; tick();
    chk("dup_head1", tx_nonce, 32'h12345678);
    idle(); rx_ack = 1; tick();
    chk("dup_empty", 32'(tx_valid), 32'd0);
    chk("dup_drops", 32'(tx_drop_count), 32'd0);

    // Overflow: 10 distinct into 8 slots.
    for (int i = 0; i < 10; i++) push(32'h1000 + i);
    chk("ovf_count", 32'(tx_count), 32'd8);
    chk("ovf_flag", 32'(tx_overflow), 32'd1);
    chk("ovf_drops", 32'(tx_drop_count), 32'd2);
    idle(); rx_new_nonce = 1; rx_golden_nonce = 32'h2000; rx_ack = 1; tick();
    chk("full_pp_count", 32'(tx_count), 32'd8);
    chk("full_pp_drops", 32'(tx_drop_count), 32'd2);
    chk("full_pp_head", tx_nonce, 32'h1000 + 1 - OFF);

    // Clear and drop together: drop wins, count restarts at one.
    idle(); rx_new_nonce = 1; rx_golden_nonce = 32'h2001; rx_clear_overflow = 1; tick();
    chk("clrdrop_flag", 32'(tx_overflow), 32'd1);
    chk("clrdrop_cnt", 32'(tx_drop_count), 32'd1);
    idle(); rx_clear_overflow = 1; tick();
    chk("clr_flag", 32'(tx_overflow), 32'd0);
    chk("clr_cnt", 32'(tx_drop_count), 32'd0);

    // Flush beats a same-cycle push and wipes the dedup history.
    idle(); rx_flush = 1; tick();
    push(32'h102); push(32'h103); push(32'h104); push(32'h5 + OFF);
    chk("fl_count4", 32'(tx_count), 32'd4);
    idle(); rx_flush = 1; rx_new_nonce = 1; rx_golden_nonce = 32'h5 + OFF; tick();
    chk("fl_count", 32'(tx_count), 32'd0);
    chk("fl_valid", 32'(tx_valid), 32'd0);
    push(32'h5 + OFF);
    chk("fl_repush_cnt", 32'(tx_count), 32'd1);
    chk("fl_repush_nonce", tx_nonce, 32'h5);

    // Asynchronous reset mid-operation.
    push(32'h300); push(32'h301);
    chk("pre_rst_count", 32'(tx_count), 32'd3);
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_count", 32'(tx_count), 32'd0);
    chk("mid_rst_nonce", tx_nonce, 32'd0);
    compare_model();
    #1 rst_n = 1'b1;

    // Random traffic, ack-starved then ack-heavy.
    for (int i = 0; i < 2000; i++) begin
      idle();
      rx_new_nonce      = ($urandom_range(0, 99) < 60);
      rx_golden_nonce   = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 3)];
      rx_ack            = ($urandom_range(0, 99) < ((i < 1000) ? 20 : 70));
      rx_flush          = ($urandom_range(0, 99) < 3);
      rx_clear_overflow = ($urandom_range(0, 99) < 5);
      tick();
    end

    // Drop counter saturation.
    idle(); rx_flush = 1; rx_clear_overflow = 1; tick();
    for (int i = 0; i < DEPTH; i++) push(32'h4000 + i);
    for (int i = 0; i < 65540; i++) push(32'h5000);
    chk("sat_cnt", 32'(tx_drop_count), 32'h0000FFFF);
    chk("sat_flag", 32'(tx_overflow), 32'd1);
    chk("sat_count", 32'(tx_count), 32'd8);
    idle(); rx_new_nonce = 1; rx_golden_nonce = 32'h5001; rx_clear_overflow = 1; tick();
    chk("sat_clrdrop", 32'(tx_drop_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
